// File: rtl/axi_rr_pkg.sv
// Shared types, sizes and the round-robin pick function for the R-channel return router.
// Slave-side ID width comes from AXI_IDS_BITS (defaults to 8).
`ifndef AXI_IDS_BITS
`define AXI_IDS_BITS 8
`endif

package axi_rr_pkg;

  localparam int NS        = 6;
  localparam int IDS       = `AXI_IDS_BITS;
  localparam int IW        = $clog2(NS);
  localparam int MSEL_BIT  = 4;
  localparam int DECERR_HI = 7;
  localparam int DECERR_LO = 5;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } rr_state_e;

  // First requesting index at or after ptr, wrapping NS-1 -> 0.
  function automatic logic [IW-1:0] rr_pick(input logic [NS-1:0] req, input logic [IW-1:0] ptr);
    logic [IW-1:0] res;
    logic          found;
    logic [IW-1:0] idx;
    res   = ptr;
    found = 1'b0;
    for (int i = 0; i < NS; i++) begin
      idx = IW'((int'(ptr) + i) % NS);
      if (!found && req[idx]) begin
        res   = idx;
        found = 1'b1;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/axi_read_return_router_rr_port_arb.sv
// Per-sink arbiter: holds one slave from grant until its RLAST handshake, then
// advances the round-robin pointer past the served slave.
//
// state | meaning
// IDLE  | no owner; registers the round-robin winner among masked requests
// BURST | slave gnt forwarded to this sink until the RLAST handshake
module rr_port_arb
  import axi_rr_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic [NS-1:0] req,
  input  logic          hs_last,
  output logic [IW-1:0] gnt,
  output logic          busy
);

  rr_state_e     state, state_nxt;
  logic [IW-1:0] ptr, ptr_nxt, gnt_nxt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      ptr   <= '0;
      gnt   <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
      gnt   <= gnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    gnt_nxt   = gnt;
    case (state)
      IDLE: begin
        if (|req) begin
          gnt_nxt   = rr_pick(req, ptr);
          state_nxt = BURST;
        end
      end
      BURST: begin
        if (hs_last) begin
          state_nxt = IDLE;
          ptr_nxt   = (gnt == IW'(NS - 1)) ? '0 : gnt + IW'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state == BURST);

endmodule

// File: rtl/axi_read_return_router.sv
// AXI R-channel return router: six slaves to two masters, one round-robin arbiter per master.
// Optional RD_RETURN_DECERR_EN adds a sink arbiter that drains beats with nonzero RID[7:5].
module axi_read_return_router
  import axi_rr_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [NS*IDS-1:0] RID_S,
  input  logic [NS*32-1:0]  RDATA_S,
  input  logic [NS*2-1:0]   RRESP_S,
  input  logic [NS-1:0]     RLAST_S,
  input  logic [NS-1:0]     RVALID_S,
  output logic [NS-1:0]     RREADY_S,
  output logic [3:0]        RID_M0,
  output logic [31:0]       RDATA_M0,
  output logic [1:0]        RRESP_M0,
  output logic              RLAST_M0,
  output logic              RVALID_M0,
  input  logic              RREADY_M0,
  output logic [3:0]        RID_M1,
  output logic [31:0]       RDATA_M1,
  output logic [1:0]        RRESP_M1,
  output logic              RLAST_M1,
  output logic              RVALID_M1,
  input  logic              RREADY_M1
`ifdef RD_RETURN_DECERR_EN
  ,
  output logic              rd_decerr
`endif
);

  logic [1:0][NS-1:0] req_m;
  logic [1:0][IW-1:0] gnt_m;
  logic [1:0]         busy_m;
  logic [1:0]         hs_m;
  logic [1:0]         rdy_m;
  logic [1:0]         vld_m;
  logic [1:0]         last_m;
  logic [1:0][3:0]    id_m;
  logic [1:0][31:0]   data_m;
  logic [1:0][1:0]    resp_m;
  logic [NS-1:0]      dec_ok;

  assign rdy_m = {RREADY_M1, RREADY_M0};

  always_comb begin
    for (int s = 0; s < NS; s++) begin
`ifdef RD_RETURN_DECERR_EN
      dec_ok[s] = (RID_S[s*IDS+DECERR_LO +: DECERR_HI-DECERR_LO+1] == '0);
`else
      dec_ok[s] = 1'b1;
`endif
      req_m[0][s] = RVALID_S[s] & ~RID_S[s*IDS+MSEL_BIT] & dec_ok[s];
      req_m[1][s] = RVALID_S[s] &  RID_S[s*IDS+MSEL_BIT] & dec_ok[s];
    end
  end

  for (genvar m = 0; m < 2; m++) begin : g_mst
    rr_port_arb u_arb (
      .clk     (clk),
      .rst     (rst),
      .req     (req_m[m]),
      .hs_last (hs_m[m]),
      .gnt     (gnt_m[m]),
      .busy    (busy_m[m])
    );
  end

  // Outputs are zero while a master has no owner, so idle masters see a quiet bus.
  always_comb begin
    int g;
    for (int m = 0; m < 2; m++) begin
      g         = int'(gnt_m[m]);
      vld_m[m]  = 1'b0;
      last_m[m] = 1'b0;
      id_m[m]   = '0;
      data_m[m] = '0;
      resp_m[m] = '0;
      if (busy_m[m]) begin
        vld_m[m]  = RVALID_S[g];
        last_m[m] = RLAST_S[g];
        id_m[m]   = RID_S[g*IDS +: 4];
        data_m[m] = RDATA_S[g*32 +: 32];
        resp_m[m] = RRESP_S[g*2 +: 2];
      end
      hs_m[m] = vld_m[m] & rdy_m[m] & last_m[m];
    end
  end

  assign RVALID_M0 = vld_m[0];
  assign RLAST_M0  = last_m[0];
  assign RID_M0    = id_m[0];
  assign RDATA_M0  = data_m[0];
  assign RRESP_M0  = resp_m[0];
  assign RVALID_M1 = vld_m[1];
  assign RLAST_M1  = last_m[1];
  assign RID_M1    = id_m[1];
  assign RDATA_M1  = data_m[1];
  assign RRESP_M1  = resp_m[1];

`ifdef RD_RETURN_DECERR_EN
  logic [IW-1:0] gnt_x;
  logic          busy_x;
  logic          hs_x;
  logic          beat_x;
  logic          decerr_q;

  rr_port_arb u_arb_sink (
    .clk     (clk),
    .rst     (rst),
    .req     (RVALID_S & ~dec_ok),
    .hs_last (hs_x),
    .gnt     (gnt_x),
    .busy    (busy_x)
  );

  // The sink is always ready, so every valid beat on its slave is a handshake.
  assign beat_x = busy_x & RVALID_S[gnt_x];
  assign hs_x   = beat_x & RLAST_S[gnt_x];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) decerr_q <= 1'b0;
    else if (beat_x) decerr_q <= 1'b1;
  end

  assign rd_decerr = decerr_q;
`endif

  always_comb begin
    RREADY_S = '0;
    for (int s = 0; s < NS; s++) begin
      for (int m = 0; m < 2; m++) begin
        if (busy_m[m] && gnt_m[m] == IW'(s)) RREADY_S[s] = RREADY_S[s] | rdy_m[m];
      end
`ifdef RD_RETURN_DECERR_EN
      if (busy_x && gnt_x == IW'(s)) RREADY_S[s] = 1'b1;
`endif
    end
  end

endmodule

// File: tb/tb_axi_read_return_router.sv
// Directed vector bench for axi_read_return_router: per-cycle table plus hand sequences
// for grant hold across a valid gap and (with RD_RETURN_DECERR_EN) the error sink.
module tb_axi_read_return_router;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [47:0]   RID_S;
  logic [191:0]  RDATA_S;
  logic [11:0]   RRESP_S;
  logic [5:0]    RLAST_S;
  logic [5:0]    RVALID_S;
  logic [5:0]    RREADY_S;
  logic [3:0]    RID_M0, RID_M1;
  logic [31:0]   RDATA_M0, RDATA_M1;
  logic [1:0]    RRESP_M0, RRESP_M1;
  logic          RLAST_M0, RLAST_M1;
  logic          RVALID_M0, RVALID_M1;
  logic          RREADY_M0, RREADY_M1;
`ifdef RD_RETURN_DECERR_EN
  logic          rd_decerr;
`endif

  int n_chk = 0;
  int n_err = 0;

  axi_read_return_router dut (
    .clk       (clk),
    .rst       (rst),
    .RID_S     (RID_S),
    .RDATA_S   (RDATA_S),
    .RRESP_S   (RRESP_S),
    .RLAST_S   (RLAST_S),
    .RVALID_S  (RVALID_S),
    .RREADY_S  (RREADY_S),
    .RID_M0    (RID_M0),
    .RDATA_M0  (RDATA_M0),
    .RRESP_M0  (RRESP_M0),
    .RLAST_M0  (RLAST_M0),
    .RVALID_M0 (RVALID_M0),
    .RREADY_M0 (RREADY_M0),
    .RID_M1    (RID_M1),
    .RDATA_M1  (RDATA_M1),
    .RRESP_M1  (RRESP_M1),
    .RLAST_M1  (RLAST_M1),
    .RVALID_M1 (RVALID_M1),
    .RREADY_M1 (RREADY_M1)
`ifdef RD_RETURN_DECERR_EN
    ,
    .rd_decerr (rd_decerr)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        r;
    logic [5:0]  v;
    logic [5:0]  l;
    logic [7:0]  b;
    logic [1:0]  rdy;
    logic [1:0]  ev;
    logic [5:0]  ers;
    logic [1:0]  el;
    logic [3:0]  eid0;
    logic [3:0]  eid1;
    logic [31:0] ed0;
    logic [31:0] ed1;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [31:0] dv(input int s, input logic [7:0] b);
    return {16'hDA7A, 8'(s), b};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic [5:0] v, input logic [5:0] l,
                       input logic [7:0] b, input logic [1:0] rdy);
    rst      = r;
    RVALID_S = v;
    RLAST_S  = l;
    for (int s = 0; s < 6; s++) RDATA_S[s*32 +: 32] = dv(s, b);
    RREADY_M0 = rdy[0];
    RREADY_M1 = rdy[1];
  endtask

  task automatic zv(input logic r, input logic [5:0] v, input logic [5:0] l, input logic [7:0] b);
    vecs.push_back('{r, v, l, b, 2'b11, 2'b00, 6'h00, 2'b00, 4'h0, 4'h0, 32'h0, 32'h0});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end");
    $fatal(1);
  end

  initial begin
    // S0 05, S1 13, S2 12, S3 01, S4 1A, S5 07
    RID_S   = {8'h07, 8'h1A, 8'h01, 8'h12, 8'h13, 8'h05};
    RRESP_S = '0;
    drive(1'b0, 6'h00, 6'h00, 8'h00, 2'b11);

    // single burst S1 -> M1
    zv(1, 6'h02, 6'h00, 8'h00);
    vecs.push_back('{1, 6'h02, 6'h00, 8'h00, 2'b11, 2'b10, 6'h02, 2'b00, 4'h0, 4'h3, 32'h0, dv(1, 8'h00)});
    vecs.push_back('{1, 6'h02, 6'h00, 8'h01, 2'b11, 2'b10, 6'h02, 2'b00, 4'h0, 4'h3, 32'h0, dv(1, 8'h01)});
    vecs.push_back('{1, 6'h02, 6'h00, 8'h02, 2'b11, 2'b10, 6'h02, 2'b00, 4'h0, 4'h3, 32'h0, dv(1, 8'h02)});
    vecs.push_back('{1, 6'h02, 6'h02, 8'h03, 2'b11, 2'b10, 6'h02, 2'b10, 4'h0, 4'h3, 32'h0, dv(1, 8'h03)});
    zv(1, 6'h00, 6'h00, 8'h00);
    // concurrent S0 -> M0, S2 -> M1
    zv(1, 6'h05, 6'h00, 8'h10);
    vecs.push_back('{1, 6'h05, 6'h00, 8'h10, 2'b11, 2'b11, 6'h05, 2'b00, 4'h5, 4'h2, dv(0, 8'h10), dv(2, 8'h10)});
    vecs.push_back('{1, 6'h05, 6'h05, 8'h11, 2'b11, 2'b11, 6'h05, 2'b11, 4'h5, 4'h2, dv(0, 8'h11), dv(2, 8'h11)});
    zv(1, 6'h00, 6'h00, 8'h00);
    // round robin S0, S3, S5 on M0 after reset
    zv(0, 6'h00, 6'h00, 8'h00);
    zv(1, 6'h29, 6'h00, 8'h20);
    vecs.push_back('{1, 6'h29, 6'h00, 8'h21, 2'b11, 2'b01, 6'h01, 2'b00, 4'h5, 4'h0, dv(0, 8'h21), 32'h0});
    vecs.push_back('{1, 6'h29, 6'h01, 8'h22, 2'b11, 2'b01, 6'h01, 2'b01, 4'h5, 4'h0, dv(0, 8'h22), 32'h0});
    zv(1, 6'h29, 6'h00, 8'h23);
    vecs.push_back('{1, 6'h29, 6'h00, 8'h24, 2'b11, 2'b01, 6'h08, 2'b00, 4'h1, 4'h0, dv(3, 8'h24), 32'h0});
    vecs.push_back('{1, 6'h29, 6'h08, 8'h25, 2'b11, 2'b01, 6'h08, 2'b01, 4'h1, 4'h0, dv(3, 8'h25), 32'h0});
    zv(1, 6'h29, 6'h00, 8'h26);
    vecs.push_back('{1, 6'h29, 6'h00, 8'h27, 2'b11, 2'b01, 6'h20, 2'b00, 4'h7, 4'h0, dv(5, 8'h27), 32'h0});
    vecs.push_back('{1, 6'h29, 6'h20, 8'h28, 2'b11, 2'b01, 6'h20, 2'b01, 4'h7, 4'h0, dv(5, 8'h28), 32'h0});
    zv(1, 6'h29, 6'h00, 8'h29);
    vecs.push_back('{1, 6'h29, 6'h00, 8'h2A, 2'b11, 2'b01, 6'h01, 2'b00, 4'h5, 4'h0, dv(0, 8'h2A), 32'h0});
    // backpressure on M0
    zv(0, 6'h00, 6'h00, 8'h00);
    zv(1, 6'h01, 6'h00, 8'h30);
    vecs.push_back('{1, 6'h01, 6'h00, 8'h30, 2'b11, 2'b01, 6'h01, 2'b00, 4'h5, 4'h0, dv(0, 8'h30), 32'h0});
    for (int k = 0; k < 3; k++)
      vecs.push_back('{1, 6'h01, 6'h00, 8'h31, 2'b10, 2'b01, 6'h00, 2'b00, 4'h5, 4'h0, dv(0, 8'h31), 32'h0});
    vecs.push_back('{1, 6'h01, 6'h00, 8'h31, 2'b11, 2'b01, 6'h01, 2'b00, 4'h5, 4'h0, dv(0, 8'h31), 32'h0});
    vecs.push_back('{1, 6'h01, 6'h01, 8'h32, 2'b11, 2'b01, 6'h01, 2'b01, 4'h5, 4'h0, dv(0, 8'h32), 32'h0});
    zv(1, 6'h00, 6'h00, 8'h00);
    // reset mid-burst
    zv(0, 6'h00, 6'h00, 8'h00);
    zv(1, 6'h02, 6'h00, 8'h40);
    vecs.push_back('{1, 6'h02, 6'h00, 8'h40, 2'b11, 2'b10, 6'h02, 2'b00, 4'h0, 4'h3, 32'h0, dv(1, 8'h40)});
    zv(0, 6'h02, 6'h00, 8'h41);
    zv(1, 6'h00, 6'h00, 8'h00);

    @(negedge clk);
    @(negedge clk);
    #1;
    chk("reset RVALID", {30'h0, RVALID_M1, RVALID_M0}, 32'h0);
    chk("reset RREADY_S", {26'h0, RREADY_S}, 32'h0);

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].r, vecs[i].v, vecs[i].l, vecs[i].b, vecs[i].rdy);
      #1;
      chk($sformatf("v%0d RVALID_M", i), {30'h0, RVALID_M1, RVALID_M0}, {30'h0, vecs[i].ev});
      chk($sformatf("v%0d RREADY_S", i), {26'h0, RREADY_S}, {26'h0, vecs[i].ers});
      chk($sformatf("v%0d RLAST_M", i), {30'h0, RLAST_M1, RLAST_M0}, {30'h0, vecs[i].el});
      chk($sformatf("v%0d RID_M0", i), {28'h0, RID_M0}, {28'h0, vecs[i].eid0});
      chk($sformatf("v%0d RID_M1", i), {28'h0, RID_M1}, {28'h0, vecs[i].eid1});
      chk($sformatf("v%0d RDATA_M0", i), RDATA_M0, vecs[i].ed0);
      chk($sformatf("v%0d RDATA_M1", i), RDATA_M1, vecs[i].ed1);
    end

    // grant held across an RVALID gap; a competing slave waits for the bubble
    @(negedge clk); drive(1'b0, 6'h00, 6'h00, 8'h00, 2'b11);
    @(negedge clk); drive(1'b1, 6'h04, 6'h00, 8'h50, 2'b11);
    #1 chk("gap idle RVALID_M1", {31'h0, RVALID_M1}, 32'h0);
    @(negedge clk); drive(1'b1, 6'h04, 6'h00, 8'h50, 2'b11);
    #1 chk("gap S2 RVALID_M1", {31'h0, RVALID_M1}, 32'h1);
    chk("gap S2 RID_M1", {28'h0, RID_M1}, 32'h2);
    @(negedge clk); drive(1'b1, 6'h02, 6'h00, 8'h51, 2'b11);
    #1 chk("gap hole RVALID_M1", {31'h0, RVALID_M1}, 32'h0);
    chk("gap hole RREADY_S", {26'h0, RREADY_S}, 32'h04);
    @(negedge clk); drive(1'b1, 6'h06, 6'h04, 8'h51, 2'b11);
    #1 chk("gap last RLAST_M1", {31'h0, RLAST_M1}, 32'h1);
    chk("gap last RDATA_M1", RDATA_M1, dv(2, 8'h51));
    chk("gap last RREADY_S", {26'h0, RREADY_S}, 32'h04);
    @(negedge clk); drive(1'b1, 6'h02, 6'h00, 8'h52, 2'b11);
    #1 chk("gap bubble RVALID_M1", {31'h0, RVALID_M1}, 32'h0);
    @(negedge clk); drive(1'b1, 6'h02, 6'h00, 8'h52, 2'b11);
    #1 chk("gap next RID_M1", {28'h0, RID_M1}, 32'h3);
    chk("gap next RREADY_S", {26'h0, RREADY_S}, 32'h02);

`ifdef RD_RETURN_DECERR_EN
    @(negedge clk); drive(1'b0, 6'h00, 6'h00, 8'h00, 2'b11);
    RID_S[39:32] = 8'h25;
    #1 chk("decerr reset", {31'h0, rd_decerr}, 32'h0);
    @(negedge clk); drive(1'b1, 6'h10, 6'h00, 8'h60, 2'b11);
    #1 chk("decerr idle RREADY_S", {26'h0, RREADY_S}, 32'h0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); drive(1'b1, 6'h10, (k == 2) ? 6'h10 : 6'h00, 8'(8'h61 + k), 2'b11);
      #1 chk($sformatf("decerr b%0d RREADY_S", k), {26'h0, RREADY_S}, 32'h10);
      chk($sformatf("decerr b%0d RVALID_M", k), {30'h0, RVALID_M1, RVALID_M0}, 32'h0);
      chk($sformatf("decerr b%0d flag", k), {31'h0, rd_decerr}, (k == 0) ? 32'h0 : 32'h1);
    end
    @(negedge clk); drive(1'b1, 6'h00, 6'h00, 8'h00, 2'b11);
    #1 chk("decerr done RREADY_S", {26'h0, RREADY_S}, 32'h0);
    chk("decerr sticky", {31'h0, rd_decerr}, 32'h1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
